// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, redirect and instruction-queue signals of the fetch controller
interface fetch_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]   imem_addr;
    logic [3:0]    imem_rmask;
    logic [31:0]   imem_rdata;
    logic          imem_resp;
    logic          branch_mispredict;
    logic [31:0]   branch_target;
    logic          q_deq;
    logic          q_push;
    logic [63:0]   q_data;
    logic [CW-1:0] q_count;
    logic          flush;
    modport master (
        output imem_addr, imem_rmask, q_push, q_data, q_count, flush,
        input  imem_rdata, imem_resp, branch_mispredict, branch_target, q_deq
    );
    modport slave (
        input  imem_addr, imem_rmask, q_push, q_data, q_count, flush,
        output imem_rdata, imem_resp, branch_mispredict, branch_target, q_deq
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch into a DEPTH-entry queue; FETCH_PERF_EN adds stall/discard counters
module fetch_ctrl #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] PC_RESET = 32'h1eceb000
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_discard_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, STALL, DISCARD} state_t;
    state_t        r_state, w_state_nx;
    logic [31:0]   r_pc, w_pc_nx;
    logic [CW-1:0] r_count, w_count_nx;
    logic          r_push;
    logic [63:0]   r_data;
    logic          w_mp, w_resp, w_accept, w_deq;
    assign w_mp   = bus.branch_mispredict;
    assign w_resp = bus.imem_resp;
    assign bus.imem_addr  = r_pc;
    assign bus.imem_rmask = (r_state == FETCH) ? 4'hF : 4'h0;
    assign bus.q_push     = r_push;
    assign bus.q_data     = r_data;
    assign bus.q_count    = r_count;
    assign bus.flush      = w_mp;
    // next state: occupancy and pc updates; a redirect wins over responses and dequeues;
    // FETCH only ever holds fewer than DEPTH entries, so an accepted response always has a slot;
    // a stale response in DISCARD ends the wait even if a further redirect arrives with it
    always_comb begin
        w_accept   = (r_state == FETCH) && w_resp && !w_mp;
        w_deq      = bus.q_deq && (r_count != '0) && !w_mp;
        w_count_nx = w_mp ? '0 : r_count + CW'(w_accept) - CW'(w_deq);
        w_pc_nx    = w_mp ? bus.branch_target : (w_accept ? r_pc + 32'd4 : r_pc);
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = FETCH;
            FETCH:   w_state_nx = w_mp ? (w_resp ? FETCH : DISCARD) : ((w_accept && w_count_nx == L_DEPTH) ? STALL : FETCH);
            STALL:   w_state_nx = (w_mp || w_count_nx < L_DEPTH) ? FETCH : STALL;
            DISCARD: w_state_nx = w_resp ? FETCH : DISCARD;
            default: w_state_nx = IDLE;
        endcase
    end
    // state, pc, occupancy and registered enqueue strobe/payload
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= PC_RESET;
            r_count <= '0;
            r_push  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_count <= w_count_nx;
            r_push  <= w_accept;
            if (w_accept) r_data <= {r_pc, bus.imem_rdata};
        end
    end
`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cycles, r_discard_count;
    logic        w_drop;
    assign w_drop          = w_resp && ((r_state == FETCH && w_mp) || r_state == DISCARD);
    assign o_stall_cycles  = r_stall_cycles;
    assign o_discard_count = r_discard_count;
    // saturating counts of stalled cycles and dropped responses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles  <= '0;
            r_discard_count <= '0;
        end else begin
            if (r_state == STALL && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_drop && !(&r_discard_count)) r_discard_count <= r_discard_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam int          DEPTH    = 8;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] PC_RESET = 32'h1eceb000;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    fetch_if #(.DEPTH(DEPTH)) bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles, discard_count;
`endif
    fetch_ctrl #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .o_stall_cycles(stall_cycles),
        .o_discard_count(discard_count)
`endif
    );
    int checks = 0;
    int errors = 0;
    logic [31:0]   m_pc = PC_RESET;
    logic [CW-1:0] m_cnt = '0;
    logic          m_push = 1'b0;
    logic [63:0]   m_data = '0;
    bit            m_idle = 1'b1;
    bit            m_drop = 1'b0;
    logic [31:0]   m_stall = '0;
    logic [31:0]   m_disc = '0;
    // requests are allowed when not just out of reset, not awaiting a stale reply, and a slot is free
    function automatic bit m_req();
        return !m_idle && !m_drop && (int'(m_cnt) < DEPTH);
    endfunction
    task automatic cycle(input bit r, input bit resp, input bit mp, input bit deq,
                         input logic [31:0] tgt, input logic [31:0] rdata);
        bit req, acc;
        rst = r;
        bus.imem_resp = resp;
        bus.branch_mispredict = mp;
        bus.q_deq = deq;
        bus.branch_target = tgt;
        bus.imem_rdata = rdata;
        @(posedge clk);
        req = m_req();
        acc = req && resp && !mp;
        if (!r) begin
            m_pc = PC_RESET; m_cnt = '0; m_push = 0; m_data = '0;
            m_idle = 1; m_drop = 0; m_stall = '0; m_disc = '0;
        end else begin
            if (!m_idle && !m_drop && int'(m_cnt) == DEPTH && m_stall != '1) m_stall++;
            if (resp && (m_drop || (req && mp)) && m_disc != '1) m_disc++;
            m_push = acc;
            if (acc) m_data = {m_pc, rdata};
            if (m_drop) m_drop = !resp;
            else m_drop = mp && req && !resp;
            m_cnt = mp ? '0 : m_cnt + CW'(acc) - CW'(deq && m_cnt != '0);
            m_pc = mp ? tgt : (acc ? m_pc + 32'd4 : m_pc);
            m_idle = 0;
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
    endtask
    task automatic test_reset();
        cycle(0, 1, 1, 1, 32'hdead0000, 32'h13);
        cycle(0, 0, 1, 0, 32'hdead0000, 0);
        checks++; if (bus.imem_addr !== PC_RESET) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, PC_RESET); end
        checks++; if (bus.imem_rmask !== 4'h0) begin errors++; $display("FAIL reset_rmask: got %h expected 0", bus.imem_rmask); end
        checks++; if (bus.q_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b expected 0", bus.q_push); end
        checks++; if (bus.q_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.q_data); end
        checks++; if (bus.q_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.q_count); end
`ifdef FETCH_PERF_EN
        checks++; if (stall_cycles !== 0 || discard_count !== 0) begin errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles, discard_count); end
`endif
        cycle(1, 0, 0, 0, 0, 0);
        checks++; if (bus.imem_rmask !== 4'hF || bus.imem_addr !== PC_RESET) begin errors++; $display("FAIL idle_to_fetch: got rmask %h addr %h expected F %h", bus.imem_rmask, bus.imem_addr, PC_RESET); end
    endtask
    task automatic test_fetch_seq();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            checks++; if (bus.imem_addr !== PC_RESET + 32'(4 * i) || bus.imem_rmask !== 4'hF) begin errors++; $display("FAIL seq_addr%0d: got %h/%h expected %h/F", i, bus.imem_addr, bus.imem_rmask, PC_RESET + 32'(4 * i)); end
            checks++; if (bus.q_push !== 1'b0) begin errors++; $display("FAIL seq_nopush%0d: got %b expected 0", i, bus.q_push); end
            cycle(1, 1, 0, 0, 0, 32'h13);
            checks++; if (bus.q_push !== 1'b1 || bus.q_data !== {PC_RESET + 32'(4 * i), 32'h13}) begin errors++; $display("FAIL seq_push%0d: got %b %h expected 1 %h", i, bus.q_push, bus.q_data, {PC_RESET + 32'(4 * i), 32'h13}); end
        end
        checks++; if (bus.q_count !== CW'(4)) begin errors++; $display("FAIL seq_count: got %0d expected 4", bus.q_count); end
    endtask
    task automatic test_fill_stall();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 0, 0, 32'(i));
        checks++; if (bus.q_count !== CW'(DEPTH) || bus.imem_rmask !== 4'h0) begin errors++; $display("FAIL fill_full: got count %0d rmask %h expected %0d 0", bus.q_count, bus.imem_rmask, DEPTH); end
        cycle(1, 0, 0, 0, 0, 0);
        checks++; if (bus.imem_rmask !== 4'h0 || bus.q_push !== 1'b0) begin errors++; $display("FAIL fill_hold: got rmask %h push %b expected 0 0", bus.imem_rmask, bus.q_push); end
        cycle(1, 0, 0, 1, 0, 0);
        checks++; if (bus.q_count !== CW'(DEPTH - 1) || bus.imem_rmask !== 4'hF || bus.imem_addr !== PC_RESET + 32'(4 * DEPTH)) begin errors++; $display("FAIL fill_resume: got %0d %h %h expected %0d F %h", bus.q_count, bus.imem_rmask, bus.imem_addr, DEPTH - 1, PC_RESET + 32'(4 * DEPTH)); end
`ifdef FETCH_PERF_EN
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL fill_stall_cycles: got %0d expected 2", stall_cycles); end
`endif
    endtask
    task automatic test_discard();
        do_reset();
        cycle(1, 1, 0, 0, 0, 32'h13);
        cycle(1, 1, 0, 0, 0, 32'h13);
        cycle(1, 0, 1, 0, 32'h1eceb100, 0);
        checks++; if (bus.imem_rmask !== 4'h0 || bus.q_count !== '0 || bus.q_push !== 1'b0) begin errors++; $display("FAIL discard_enter: got %h %0d %b expected 0 0 0", bus.imem_rmask, bus.q_count, bus.q_push); end
        cycle(1, 0, 0, 0, 0, 0);
        checks++; if (bus.imem_rmask !== 4'h0) begin errors++; $display("FAIL discard_wait: got %h expected 0", bus.imem_rmask); end
        cycle(1, 1, 0, 0, 0, $urandom);
        checks++; if (bus.q_push !== 1'b0 || bus.q_count !== '0 || bus.imem_rmask !== 4'hF || bus.imem_addr !== 32'h1eceb100) begin errors++; $display("FAIL discard_drop: got %b %0d %h %h expected 0 0 F 1eceb100", bus.q_push, bus.q_count, bus.imem_rmask, bus.imem_addr); end
        cycle(1, 1, 0, 0, 0, 32'h13);
        checks++; if (bus.q_push !== 1'b1 || bus.q_data !== {32'h1eceb100, 32'h13}) begin errors++; $display("FAIL discard_next: got %b %h expected 1 1eceb10000000013", bus.q_push, bus.q_data); end
    endtask
    task automatic test_mp_resp();
        do_reset();
        cycle(1, 1, 1, 1, 32'h00002000, 32'h13);
        checks++; if (bus.q_push !== 1'b0 || bus.imem_addr !== 32'h00002000 || bus.imem_rmask !== 4'hF || bus.q_count !== '0) begin errors++; $display("FAIL mp_resp: got %b %h %h %0d expected 0 00002000 F 0", bus.q_push, bus.imem_addr, bus.imem_rmask, bus.q_count); end
`ifdef FETCH_PERF_EN
        checks++; if (discard_count !== 32'd1) begin errors++; $display("FAIL mp_resp_discard: got %0d expected 1", discard_count); end
`endif
    endtask
    task automatic test_deq_empty();
        do_reset();
        cycle(1, 1, 0, 1, 0, 32'h13);
        checks++; if (bus.q_count !== CW'(1) || bus.q_push !== 1'b1) begin errors++; $display("FAIL deq_empty: got %0d %b expected 1 1", bus.q_count, bus.q_push); end
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 32'h00004000, 32'h13);
        checks++; if (bus.imem_addr !== PC_RESET || bus.imem_rmask !== 4'h0 || bus.q_push !== 1'b0 || bus.q_data !== 64'h0 || bus.q_count !== '0) begin errors++; $display("FAIL mid_reset: got %h %h %b %h %0d expected reset values", bus.imem_addr, bus.imem_rmask, bus.q_push, bus.q_data, bus.q_count); end
    endtask
    task automatic test_random();
        bit r, resp, mp, deq;
        logic [31:0] tgt;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            r    = ($urandom % 300) != 0;
            resp = (m_req() || m_drop) && ($urandom % 3 == 0);
            mp   = ($urandom % 25) == 0;
            deq  = ($urandom % 4) == 0;
            tgt  = ($urandom % 2) ? 32'hFFFFFFF0 : {$urandom_range(32'h3FFFFFFF, 0), 2'b00};
            bus.branch_mispredict = mp;
            #1;
            checks++; if (bus.flush !== mp) begin errors++; $display("FAIL rnd_flush@%0d: got %b expected %b", n, bus.flush, mp); end
            cycle(r, resp, mp, deq, tgt, $urandom);
            checks++; if (bus.imem_rmask !== (m_req() ? 4'hF : 4'h0)) begin errors++; $display("FAIL rnd_rmask@%0d: got %h expected %h", n, bus.imem_rmask, m_req() ? 4'hF : 4'h0); end
            if (m_req()) begin
                checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", n, bus.imem_addr, m_pc); end
            end
            checks++; if (bus.q_push !== m_push) begin errors++; $display("FAIL rnd_push@%0d: got %b expected %b", n, bus.q_push, m_push); end
            if (m_push) begin
                checks++; if (bus.q_data !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", n, bus.q_data, m_data); end
            end
            checks++; if (bus.q_count !== m_cnt || int'(bus.q_count) > DEPTH) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, bus.q_count, m_cnt); end
`ifdef FETCH_PERF_EN
            checks++; if (stall_cycles !== m_stall || discard_count !== m_disc) begin errors++; $display("FAIL rnd_perf@%0d: got %0d/%0d expected %0d/%0d", n, stall_cycles, discard_count, m_stall, m_disc); end
`endif
        end
    endtask
    initial begin
        bus.imem_resp = 0;
        bus.branch_mispredict = 0;
        bus.q_deq = 0;
        bus.branch_target = 0;
        bus.imem_rdata = 0;
        @(negedge clk);
        test_reset();
        test_fetch_seq();
        test_fill_stall();
        test_discard();
        test_mp_resp();
        test_deq_empty();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, SHALL be the instruction-queue entry count this controller tracks; power of two, >=2.
REQ-002 Parameter PC_RESET, default 32'h1eceb000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 imem_addr  output  32  fetch address, word aligned.
REQ-006 imem_rmask  output  4  4'hF = request valid, 4'h0 = no request.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_resp.
REQ-008 imem_resp  input  1  one-cycle response pulse for the outstanding request.
REQ-009 branch_mispredict  input  1  redirect pulse from the ROB.
REQ-010 branch_target  input  32  redirect PC, valid with branch_mispredict.
REQ-011 q_deq  input  1  dispatch pops one queue entry this cycle.
REQ-012 q_push  output  1  registered enqueue strobe to the instruction queue.
REQ-013 q_data  output  64  registered enqueue payload {pc[31:0], inst[31:0]}.
REQ-014 q_count  output  $clog2(DEPTH)+1  entries held plus push in flight.
REQ-015 flush  output  1  combinational copy of branch_mispredict, drives queue flush.

Function
REQ-016 States SHALL be IDLE, FETCH, STALL, DISCARD; imem_rmask SHALL be 4'hF only in FETCH.
REQ-017 IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-018 In FETCH, imem_addr SHALL equal pc and be held stable until imem_resp.
REQ-019 On imem_resp in FETCH (no mispredict), next cycle SHALL show q_push=1, q_data={pc, imem_rdata}, pc+4, and q_count incremented.
REQ-020 q_push SHALL be high exactly one cycle per accepted response; otherwise 0.
REQ-021 q_count next = q_count + accepted_resp - (q_deq && q_count!=0); q_deq with q_count==0 SHALL be ignored.
REQ-022 After an accepted response, state SHALL remain FETCH if next q_count < DEPTH, else go STALL.
REQ-023 STALL SHALL go to FETCH in the cycle after q_count drops below DEPTH.
REQ-024 q_count SHALL never exceed DEPTH; no response is requested without a free slot.
REQ-025 On branch_mispredict: pc<=branch_target, q_count<=0, q_push<=0, q_deq ignored that cycle.
REQ-026 Mispredict in FETCH without imem_resp SHALL go DISCARD; with imem_resp the same cycle the response SHALL be dropped and state go FETCH.
REQ-027 Mispredict in IDLE or STALL SHALL go FETCH; in DISCARD SHALL update pc and stay DISCARD.
REQ-028 DISCARD SHALL hold imem_rmask=0, drop the next imem_resp without push, then go FETCH.
REQ-029 pc arithmetic SHALL be modulo 2^32 (wraps at 32'hFFFFFFFC).

Reset
REQ-030 With rst low at a clock edge: state=IDLE, pc=PC_RESET, imem_rmask=0, q_push=0, q_data=0, q_count=0; reset dominates mispredict and responses.
REQ-031 Reset mid-request SHALL abandon the outstanding request; controller does not wait for its response.

Configuration
REQ-032 With FETCH_PERF_EN defined, outputs stall_cycles[31:0] (cycles in STALL) and discard_count[31:0] (dropped responses) SHALL exist, clear on reset, saturate at all-ones.
REQ-033 Without FETCH_PERF_EN those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset release, imem_resp every 2nd cycle, rdata=32'h00000013 -> addrs 1eceb000, 1eceb004, ...; one q_push per resp with matching pc.
REQ-035 No q_deq, responses always ready -> exactly 8 pushes, q_count=8, state STALL, rmask=0; one q_deq -> FETCH next cycle.
REQ-036 Mispredict target 32'h1eceb100 while request pending -> DISCARD; next resp dropped, q_count=0, next addr 1eceb100.
REQ-037 Mispredict coincident with imem_resp -> no q_push, next request addr = target, discard_count+1 if FETCH_PERF_EN.
REQ-038 q_deq with q_count=0 and simultaneous resp -> q_count=1; rst low mid-FETCH -> all outputs at reset values next cycle.
